tl_cntr_param: RTL and testbench
================================

Name: tl_cntr_param

Overview:
Parametrised two-road traffic light controller with protected left-turn phases and per-phase timing. It is the timed successor of the fixed-step left-turn controller. Every green phase has a minimum and a maximum length in clock cycles. Yellow length is configurable. Left-turn phases are skipped when there is no demand for them. Sits at the top of the intersection design and drives the lamp decoders for road A and road B.

Parameters:
YELLOW_CYC, 2, yellow phase length in cycles (>=1)
MIN_GREEN, 3, minimum cycles in any green or left-arrow phase (>=1)
MAX_GREEN, 8, maximum cycles in a green phase while another demand is pending (>=MIN_GREEN)
CNT_W, 4, phase timer width; must hold MAX_GREEN-1 and YELLOW_CYC-1

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
Ta  input  1  road A straight traffic present
Tb  input  1  road B straight traffic present
Tal  input  1  road A left-turn traffic present
Tbl  input  1  road B left-turn traffic present
La  output  2  road A lamp: 00 green, 01 yellow, 10 red, 11 left arrow
Lb  output  2  road B lamp, same encoding
phase  output  3  current state code, for debug and verification
phase_cnt  output  CNT_W  cycles elapsed in the current phase

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset: state AG, phase_cnt=0, La=00, Lb=10. Reset asserted mid-phase forces this immediately, without waiting for a clock edge.
- Moore outputs: La, Lb and phase are decoded from the state register only. Inputs are sampled on the rising edge of clk. A transition takes effect at the same edge its condition is seen.
- States and encoding: AG=0, AY=1, AL=2, ALY=3, BG=4, BY=5, BL=6, BLY=7.
- Lamp outputs per state:
  - AG: La=00, Lb=10
  - AY and ALY: La=01, Lb=10
  - AL: La=11, Lb=10
  - BG: La=10, Lb=00
  - BY and BLY: La=10, Lb=01
  - BL: La=10, Lb=11
- phase_cnt: cleared to 0 on every state change. Otherwise increments by 1 per cycle and saturates at 2^CNT_W-1.
- "min_ok" means phase_cnt >= MIN_GREEN-1. "max_hit" means phase_cnt >= MAX_GREEN-1. "yel_done" means phase_cnt == YELLOW_CYC-1.
- AG -> AY when min_ok and other_dem and (!Ta or max_hit), where other_dem = Tb|Tbl|Tal. With no other demand, AG holds indefinitely (rest-in-green on A).
- AY -> AL on yel_done if Tal=1; AY -> BG on yel_done if Tal=0.
- AL -> ALY when min_ok and (!Tal or max_hit). ALY -> BG on yel_done.
- BG -> BY when min_ok and (!Tb or max_hit). BG never holds for lack of other demand; it always returns toward A.
- BY -> BL on yel_done if Tbl=1; BY -> AG on yel_done if Tbl=0.
- BL -> BLY when min_ok and (!Tbl or max_hit). BLY -> AG on yel_done.
- Left-turn demand is sampled only at the yellow-expiry edge. A demand that arrives and drops during green is lost.
- Safety invariant: at least one of La and Lb is 10 in every cycle. Never are both non-red.
- YELLOW_CYC=1 gives single-cycle yellow. MIN_GREEN=1 allows exit after one cycle.

Decomposition:
- Package tl_pkg holds:
  - lamp constants L_GREEN=2'b00, L_YELLOW=2'b01, L_RED=2'b10, L_LEFT=2'b11
  - the 3-bit state encodings AG..BLY
- One sub-module, tl_phase_timer: a CNT_W counter with synchronous clear-on-transition and saturation, asynchronous reset to 0. It outputs phase_cnt.
- The next-state logic, state register and output decode stay in tl_cntr_param.

Test Plan:
1. Reset, then Ta=1, Tb=Tal=Tbl=0 for 20 cycles -> phase=0 throughout, La=00, Lb=10, phase_cnt saturates.
2. After reset, Ta=0, Tb=1 -> AG lasts 3 cycles, AY 2 cycles, then BG. La sequence is 00,00,00,01,01,10; Lb is 00 at cycle 5.
3. Ta=1, Tb=1 continuously -> AG lasts exactly 8 cycles (MAX_GREEN), then AY(2), then BG. BG lasts 8 cycles, then BY(2), then AG.
4. Tal=1 at AY expiry, then dropped 4 cycles later -> AL with La=11 for 4 cycles, ALY(2), then BG. Tbl=1 at BY expiry -> BL with Lb=11.
5. Assert reset_n=0 mid-AL, off the clock edge -> La=00, Lb=10, phase_cnt=0 before the next clk edge. Operation resumes normally after release.
6. Instance with YELLOW_CYC=1, MIN_GREEN=1, MAX_GREEN=4 and all demands high -> full rotation AG4, AY1, AL4, ALY1, BG4, BY1, BL4, BLY1 = 20 cycles. A checker asserts the one-red invariant every cycle.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared encodings for the timed two-road traffic light controller:
// lamp codes, state codes and the state-to-lamp decode.
package tl_pkg;

  localparam logic [1:0] L_GREEN  = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_RED    = 2'b10;
  localparam logic [1:0] L_LEFT   = 2'b11;

  typedef enum logic [2:0] {
    AG  = 3'd0,
    AY  = 3'd1,
    AL  = 3'd2,
    ALY = 3'd3,
    BG  = 3'd4,
    BY  = 3'd5,
    BL  = 3'd6,
    BLY = 3'd7
  } state_t;

  // Returns {La, Lb}; every entry keeps at least one road red.
  function automatic logic [3:0] lamp_decode(input state_t s);
    logic [3:0] lamps;
    lamps = {L_GREEN, L_RED};
    case (s)
      AG:       lamps = {L_GREEN,  L_RED};
      AY, ALY:  lamps = {L_YELLOW, L_RED};
      AL:       lamps = {L_LEFT,   L_RED};
      BG:       lamps = {L_RED,    L_GREEN};
      BY, BLY:  lamps = {L_RED,    L_YELLOW};
      BL:       lamps = {L_RED,    L_LEFT};
      default:  lamps = {L_GREEN,  L_RED};
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase timer: counts cycles spent in the current phase, restarts at 0 on
// a phase change and holds at all-ones instead of wrapping.
module tl_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  output logic [CNT_W-1:0] phase_cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_cnt <= '0;
    end else if (clear) begin
      phase_cnt <= '0;
    end else if (phase_cnt != {CNT_W{1'b1}}) begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tl_cntr_param.sv
// Two-road traffic light controller with demand-driven protected left turns
// and per-phase minimum/maximum green timing. Rests in green on road A.
module tl_cntr_param
  import tl_pkg::*;
#(
  parameter int YELLOW_CYC = 2,
  parameter int MIN_GREEN  = 3,
  parameter int MAX_GREEN  = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Ta,
  input  logic             Tb,
  input  logic             Tal,
  input  logic             Tbl,
  output logic [1:0]       La,
  output logic [1:0]       Lb,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] phase_cnt
);

  localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LIM = CNT_W'(YELLOW_CYC - 1);

  state_t state;
  state_t state_next;
  logic   min_ok;
  logic   max_hit;
  logic   yel_done;
  logic   other_dem;

  assign min_ok    = (phase_cnt >= MIN_LIM);
  assign max_hit   = (phase_cnt >= MAX_LIM);
  assign yel_done  = (phase_cnt == YEL_LIM);
  assign other_dem = Tb | Tbl | Tal;

  always_comb begin
    state_next = state;
    case (state)
      AG:  if (min_ok && other_dem && (!Ta || max_hit)) state_next = AY;
      AY:  if (yel_done) state_next = Tal ? AL : BG;
      AL:  if (min_ok && (!Tal || max_hit)) state_next = ALY;
      ALY: if (yel_done) state_next = BG;
      // BG always hands back toward A once its own demand is served.
      BG:  if (min_ok && (!Tb || max_hit)) state_next = BY;
      BY:  if (yel_done) state_next = Tbl ? BL : AG;
      BL:  if (min_ok && (!Tbl || max_hit)) state_next = BLY;
      BLY: if (yel_done) state_next = AG;
      default: state_next = AG;
    endcase
  end

  // Lamps are registered from the next state so they always track the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= AG;
      La    <= L_GREEN;
      Lb    <= L_RED;
    end else begin
      state    <= state_next;
      {La, Lb} <= lamp_decode(state_next);
    end
  end

  assign phase = state;

  tl_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state_next != state),
    .phase_cnt(phase_cnt)
  );

endmodule

// File: tb/tb_tl_cntr_param.sv
// Directed bench for tl_cntr_param: default timing instance plus a fast
// instance (yellow 1, min 1, max 4) with a per-cycle one-red checker.
module tb_tl_cntr_param;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       reset_n2 = 1'b1;
  logic       ta = 1'b0, tb = 1'b0, tal = 1'b0, tbl = 1'b0;
  logic [1:0] la, lb, la2, lb2;
  logic [2:0] phase, phase2;
  logic [3:0] phase_cnt, phase_cnt2;
  logic       armed = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Lamp codes per state code 0..7 (AG AY AL ALY BG BY BL BLY).
  logic [1:0] la_tab [8] = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
  logic [1:0] lb_tab [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b01};

  int exp3 [21] = '{0,0,0,0,0,0,0,0,1,1,4,4,4,4,4,4,4,4,5,5,0};
  int exp4 [32] = '{0,0,0,1,1,2,2,2,2,3,3,4,4,4,4,4,4,4,4,5,5,6,6,6,6,6,6,6,6,7,7,0};
  int exp6 [21] = '{0,0,0,0,1,2,2,2,2,3,4,4,4,4,5,6,6,6,6,7,0};
  logic [1:0] exp2_la [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};

  tl_cntr_param dut (
    .clk(clk), .reset_n(reset_n),
    .Ta(ta), .Tb(tb), .Tal(tal), .Tbl(tbl),
    .La(la), .Lb(lb), .phase(phase), .phase_cnt(phase_cnt)
  );

  tl_cntr_param #(.YELLOW_CYC(1), .MIN_GREEN(1), .MAX_GREEN(4), .CNT_W(4)) dut2 (
    .clk(clk), .reset_n(reset_n2),
    .Ta(1'b1), .Tb(1'b1), .Tal(1'b1), .Tbl(1'b1),
    .La(la2), .Lb(lb2), .phase(phase2), .phase_cnt(phase_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges and confirm the reset state appears without a clock.
  task automatic do_reset();
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_la", 32'(la), 32'd0);
    chk("rst_lb", 32'(lb), 32'd2);
    chk("rst_cnt", 32'(phase_cnt), 32'd0);
    #1 reset_n = 1'b1;
  endtask

  // One-red invariant on both instances every cycle.
  always @(negedge clk) begin
    if (armed) begin
      chk("one_red", 32'((la == 2'b10) || (lb == 2'b10)), 32'd1);
      chk("one_red2", 32'((la2 == 2'b10) || (lb2 == 2'b10)), 32'd1);
    end
  end

  initial begin
    #1 reset_n = 1'b0; reset_n2 = 1'b0;
    #1 armed = 1'b1;

    // 1: rest in green on A
    ta = 1'b1; tb = 1'b0; tal = 1'b0; tbl = 1'b0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("t1_phase_c%0d", c), 32'(phase), 32'd0);
      chk($sformatf("t1_la_c%0d", c), 32'(la), 32'd0);
      tick();
    end
    chk("t1_cnt_sat", 32'(phase_cnt), 32'd15);

    // 2: B demand only, A minimum green then yellow
    ta = 1'b0; tb = 1'b1;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("t2_la_c%0d", c), 32'(la), 32'(exp2_la[c]));
      if (c == 5) chk("t2_lb_c5", 32'(lb), 32'd0);
      tick();
    end

    // 3: both straight demands, max green both ways
    ta = 1'b1; tb = 1'b1;
    do_reset();
    for (int c = 0; c < 21; c++) begin
      chk($sformatf("t3_phase_c%0d", c), 32'(phase), 32'(exp3[c]));
      chk($sformatf("t3_la_c%0d", c), 32'(la), 32'(la_tab[exp3[c]]));
      chk($sformatf("t3_lb_c%0d", c), 32'(lb), 32'(lb_tab[exp3[c]]));
      if (c == 7) chk("t3_cnt_c7", 32'(phase_cnt), 32'd7);
      tick();
    end

    // 4: left-turn phases on both roads
    ta = 1'b0; tb = 1'b1; tal = 1'b1; tbl = 1'b1;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      if (c == 8) tal = 1'b0;
      chk($sformatf("t4_phase_c%0d", c), 32'(phase), 32'(exp4[c]));
      chk($sformatf("t4_la_c%0d", c), 32'(la), 32'(la_tab[exp4[c]]));
      chk($sformatf("t4_lb_c%0d", c), 32'(lb), 32'(lb_tab[exp4[c]]));
      tick();
    end

    // 5: asynchronous reset in the middle of AL, then normal restart
    ta = 1'b0; tb = 1'b0; tal = 1'b1; tbl = 1'b0;
    do_reset();
    for (int c = 0; c < 6; c++) tick();
    chk("t5_in_al", 32'(phase), 32'd2);
    chk("t5_al_lamp", 32'(la), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_phase", 32'(phase), 32'd0);
    chk("t5_async_la", 32'(la), 32'd0);
    chk("t5_async_lb", 32'(lb), 32'd2);
    chk("t5_async_cnt", 32'(phase_cnt), 32'd0);
    #1 reset_n = 1'b1;
    tal = 1'b0; tb = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t5_resume_c%0d", c), 32'(phase), (c == 3) ? 32'd1 : 32'd0);
      tick();
    end

    // 6: fast instance, full 20-cycle rotation with all demands
    #2 reset_n2 = 1'b1;
    for (int c = 0; c < 21; c++) begin
      chk($sformatf("t6_phase_c%0d", c), 32'(phase2), 32'(exp6[c]));
      chk($sformatf("t6_la_c%0d", c), 32'(la2), 32'(la_tab[exp6[c]]));
      chk($sformatf("t6_lb_c%0d", c), 32'(lb2), 32'(lb_tab[exp6[c]]));
      tick();
    end

    armed = 1'b0;
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
